// File: rtl/ccu_ctrl_pkg.sv
// rtl/ccu_ctrl_pkg.sv - shared CCU control-path types and helpers
package ccu_ctrl_pkg;

  localparam int unsigned CdDataWidth = 64;

  typedef struct packed {
    logic [CdDataWidth-1:0] data;
    logic                   last;
  } snoop_cd_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } cd_router_state_e;

  // Index width that stays legal for a single-entry range.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ccu_cd_router_if.sv
// rtl/ccu_cd_router_if.sv - command, master-port CD and sink-side bundle of the CD router
interface ccu_cd_router_if #(
  parameter int unsigned NoMstPorts = 4,
  parameter int unsigned NoSinks    = 2
);
  localparam int unsigned PortW = ccu_ctrl_pkg::idx_width(NoMstPorts);

  logic                                     cmd_valid_i;
  logic                                     cmd_ready_o;
  logic [PortW-1:0]                         cmd_port_i;
  logic [NoSinks-1:0]                       cmd_sinks_i;
  ccu_ctrl_pkg::snoop_cd_t [NoMstPorts-1:0] cd_i;
  logic [NoMstPorts-1:0]                    cd_valid_i;
  logic [NoMstPorts-1:0]                    cd_ready_o;
  ccu_ctrl_pkg::snoop_cd_t                  sink_cd_o;
  logic [NoSinks-1:0]                       sink_valid_o;
  logic [NoSinks-1:0]                       sink_ready_i;
  logic                                     sink_last_o;
  logic [PortW-1:0]                         sink_port_o;
  logic                                     busy_o;
  logic                                     err_o;

  modport master (
    output cmd_valid_i, cmd_port_i, cmd_sinks_i, cd_i, cd_valid_i, sink_ready_i,
    input  cmd_ready_o, cd_ready_o, sink_cd_o, sink_valid_o, sink_last_o,
           sink_port_o, busy_o, err_o
  );

  modport slave (
    input  cmd_valid_i, cmd_port_i, cmd_sinks_i, cd_i, cd_valid_i, sink_ready_i,
    output cmd_ready_o, cd_ready_o, sink_cd_o, sink_valid_o, sink_last_o,
           sink_port_o, busy_o, err_o
  );
endinterface

// File: rtl/ccu_cd_router_fifo.sv
// rtl/ccu_cd_router_fifo.sv - route-command queue, registered output (not fall-through)
module ccu_cd_router_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PtrW = ccu_ctrl_pkg::idx_width(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  // A push against a full queue is refused even when a pop frees a slot this cycle.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
    mem_q <= mem_d;
  end
endmodule

// File: rtl/ccu_cd_router.sv
// rtl/ccu_cd_router.sv - command-driven CD crossbar: one line from a master port to a sink subset
module ccu_cd_router
  import ccu_ctrl_pkg::*;
#(
  parameter int unsigned NoMstPorts      = 4,
  parameter int unsigned NoSinks         = 2,
  parameter int unsigned DcacheLineWords = 2,
  parameter int unsigned CmdDepth        = 2
) (
  input logic              clk_i,
  input logic              rst_i,
  ccu_cd_router_if.slave   bus
);
  localparam int unsigned PortW = idx_width(NoMstPorts);
  localparam int unsigned CntW  = idx_width(DcacheLineWords);
  localparam logic [CntW-1:0] LastCnt = CntW'(DcacheLineWords - 1);

  typedef struct packed {
    logic [PortW-1:0]   port;
    logic [NoSinks-1:0] sinks;
  } cmd_t;

  cmd_t               cmd_in, cmd_head;
  logic               fifo_full, fifo_empty, fifo_pop;
  cd_router_state_e   state_q, state_d;
  logic [PortW-1:0]   port_q, port_d;
  logic [NoSinks-1:0] sinks_q, sinks_d, taken_q, taken_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               xfer, cur_valid, done, hs, last_beat;
  logic [NoSinks-1:0] sink_valid;
  snoop_cd_t          cur_cd;

  assign cmd_in.port  = bus.cmd_port_i;
  assign cmd_in.sinks = bus.cmd_sinks_i;

  ccu_cd_router_fifo #(
    .Depth (CmdDepth),
    .Width ($bits(cmd_t))
  ) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (bus.cmd_valid_i),
    .data_i  (cmd_in),
    .pop_i   (fifo_pop),
    .data_o  (cmd_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign xfer       = (state_q == XFER);
  assign cur_cd     = bus.cd_i[port_q];
  assign cur_valid  = xfer & bus.cd_valid_i[port_q];
  // Sinks already holding this beat, or not addressed, no longer gate the source.
  assign done       = &(~sinks_q | taken_q | bus.sink_ready_i);
  assign last_beat  = (cnt_q == LastCnt);
  assign hs         = cur_valid & done;
  assign fifo_pop   = ~fifo_empty & (~xfer | (hs & last_beat));
  assign sink_valid = {NoSinks{cur_valid}} & sinks_q & ~taken_q;

  assign bus.cmd_ready_o  = ~fifo_full;
  assign bus.sink_valid_o = sink_valid;
  assign bus.sink_cd_o    = xfer ? cur_cd : '0;
  assign bus.sink_last_o  = xfer & last_beat;
  assign bus.sink_port_o  = port_q;
  assign bus.busy_o       = xfer;
  assign bus.err_o        = hs & (cur_cd.last != last_beat);

  always_comb begin
    bus.cd_ready_o = '0;
    if (xfer) begin
      bus.cd_ready_o[port_q] = done;
    end
  end

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    sinks_d = sinks_q;
    cnt_d   = cnt_q;
    taken_d = taken_q;
    if (fifo_pop) begin
      state_d = XFER;
      port_d  = cmd_head.port;
      sinks_d = cmd_head.sinks;
      cnt_d   = '0;
      taken_d = '0;
    end else if (hs && last_beat) begin
      state_d = IDLE;
      cnt_d   = '0;
      taken_d = '0;
    end else if (hs) begin
      cnt_d   = cnt_q + CntW'(1);
      taken_d = '0;
    end else if (xfer) begin
      taken_d = taken_q | (sinks_q & sink_valid & bus.sink_ready_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      port_q  <= '0;
      sinks_q <= '0;
      cnt_q   <= '0;
      taken_q <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      sinks_q <= sinks_d;
      cnt_q   <= cnt_d;
      taken_q <= taken_d;
    end
  end
endmodule
